// File: rtl/apb_master_if.sv
// APB bus between one requester and one slave; signal names follow the requester's view.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;

  modport master (
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    input  prdata_i, pready_i
  );

  modport slave (
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    output prdata_i, pready_i
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: command strobe -> SETUP -> ACCESS (waits, timeout) -> done.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic [1:0]        add_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  apb_master_if.master      apb
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              psel, psel_n, pen, pen_n, pwrite, pwrite_n;
  logic [ADDR_W-1:0] paddr, paddr_n;
  logic [DATA_W-1:0] pwdata, pwdata_n, rdata, rdata_n;
  logic              done, done_n, err, err_n;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      psel   <= 1'b0;
      pen    <= 1'b0;
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      rdata  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      psel   <= psel_n;
      pen    <= pen_n;
      pwrite <= pwrite_n;
      paddr  <= paddr_n;
      pwdata <= pwdata_n;
      rdata  <= rdata_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    psel_n   = psel;
    pen_n    = pen;
    pwrite_n = pwrite;
    paddr_n  = paddr;
    pwdata_n = pwdata;
    rdata_n  = rdata;
    done_n   = 1'b0;
    err_n    = err;
    case (state)
      IDLE: begin
        // add_i[0] set means READ (01) or WRITE (11); 00/10 are NOPs
        if (add_i[0]) begin
          paddr_n  = addr_i;
          pwrite_n = add_i[1];
          if (add_i[1]) pwdata_n = wdata_i;
          psel_n   = 1'b1;
          cnt_n    = '0;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        pen_n   = 1'b1;
        state_n = ACCESS;
      end
      ACCESS: begin
        if (apb.pready_i) begin
          if (!pwrite) rdata_n = apb.prdata_i;
          done_n  = 1'b1;
          err_n   = 1'b0;
          psel_n  = 1'b0;
          pen_n   = 1'b0;
          state_n = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // this edge is the TIMEOUT-th not-ready ACCESS edge: abort
          done_n  = 1'b1;
          err_n   = 1'b1;
          psel_n  = 1'b0;
          pen_n   = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign apb.psel_o    = psel;
  assign apb.penable_o = pen;
  assign apb.paddr_o   = paddr;
  assign apb.pwrite_o  = pwrite;
  assign apb.pwdata_o  = pwdata;
  assign busy_o        = psel;
  assign done_o        = done;
  assign err_o         = err;
  assign rdata_o       = rdata;
endmodule

// File: tb/tb_apb_master.sv
// Directed and random APB transfers checked against a transaction-level model of latency/data.
module tb_apb_master;
  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic [1:0]  add_i = 2'b00;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n), .add_i(add_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .apb(bus.master)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0, n_fail = 0;

  // transaction-level expectations
  logic [31:0] m_paddr = '0, m_pwdata = '0, m_rdata = '0;
  logic        m_pwrite = 1'b0, m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  // One transfer; w = not-ready ACCESS cycles the slave inserts, inj = push commands while busy.
  task automatic xfer(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int w, input bit inj);
    int k, sel_n, pen_n, exp_edges;
    bit got, exp_err;
    add_i = cmd; addr_i = a; wdata_i = wd;
    bus.pready_i = 1'b0; bus.prdata_i = rd;
    m_paddr = a; m_pwrite = cmd[1];
    if (cmd[1]) m_pwdata = wd;
    exp_err   = (w >= TO);
    exp_edges = exp_err ? TO + 1 : w + 2;
    got = 0; k = 0; sel_n = 0; pen_n = 0;
    while (!got && k < 40) begin
      tick(); k++;
      add_i   = inj ? ($urandom_range(0, 1) ? 2'b11 : 2'b01) : 2'b00;
      addr_i  = $urandom; wdata_i = $urandom;
      bus.pready_i = (k - 2 == w);
      if (done_o) begin
        got = 1;
        chk("done_edges", k - 1, exp_edges);
        chk("err", err_o, exp_err);
        if (!cmd[1] && !exp_err) m_rdata = rd;
        m_err = exp_err;
        chk("rdata", rdata_o, m_rdata);
        chk("psel_end", bus.psel_o, 0);
        chk("pen_end", bus.penable_o, 0);
        chk("busy_end", busy_o, 0);
      end else begin
        if (bus.psel_o) sel_n++;
        if (bus.penable_o) pen_n++;
        chk("psel", bus.psel_o, 1);
        chk("busy", busy_o, 1);
        chk("pen", bus.penable_o, k >= 2);
        chk("paddr", bus.paddr_o, m_paddr);
        chk("pwrite", bus.pwrite_o, m_pwrite);
        chk("pwdata", bus.pwdata_o, m_pwdata);
      end
    end
    if (!got) chk("done_bound", 0, 1);
    chk("sel_cycles", sel_n, exp_edges);
    chk("pen_cycles", pen_n, exp_edges - 1);
    bus.pready_i = 1'b0; add_i = 2'b00;
    tick();
    chk("done_pulse", done_o, 0);
    chk("idle_psel", bus.psel_o, 0);
    chk("err_hold", err_o, m_err);
    chk("rdata_hold", rdata_o, m_rdata);
    chk("paddr_hold", bus.paddr_o, m_paddr);
  endtask

  initial begin
    bus.pready_i = 1'b0; bus.prdata_i = '0;
    #12;
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_pen", bus.penable_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    preset_n = 1'b1;
    tick();

    xfer(2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    xfer(2'b11, 32'h24, 32'hA5A5_0001, 32'h1234_5678, 2, 0);

    for (int i = 0; i < 5; i++) begin
      add_i = i[0] ? 2'b10 : 2'b00;
      tick();
      chk("nop_psel", bus.psel_o, 0);
      chk("nop_done", done_o, 0);
      chk("nop_busy", busy_o, 0);
    end
    add_i = 2'b00;

    xfer(2'b11, 32'h30, 32'hCAFE_0002, 32'h0, 1, 1);
    xfer(2'b01, 32'h40, 32'h0, 32'hBAD0_BAD0, 100, 0);
    xfer(2'b01, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 0);

    // reset mid-ACCESS
    add_i = 2'b01; addr_i = 32'h50; bus.pready_i = 1'b0;
    tick(); add_i = 2'b00;
    tick();
    chk("pre_rst_pen", bus.penable_o, 1);
    #2 preset_n = 1'b0;
    #1;
    chk("arst_psel", bus.psel_o, 0);
    chk("arst_pen", bus.penable_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    m_paddr = '0; m_pwdata = '0; m_pwrite = 0; m_rdata = '0; m_err = 0;
    tick();
    preset_n = 1'b1;
    tick();
    chk("post_rst_done", done_o, 0);
    chk("post_rst_psel", bus.psel_o, 0);
    xfer(2'b01, 32'h54, 32'h0, 32'h7777_1111, 0, 0);

    for (int t = 0; t < 25; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        add_i = $urandom_range(0, 1) ? 2'b10 : 2'b00;
        tick();
        chk("gap_done", done_o, 0);
        chk("gap_psel", bus.psel_o, 0);
      end
      xfer($urandom_range(0, 1) ? 2'b11 : 2'b01, $urandom, $urandom, $urandom,
           $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns a single-cycle command strobe (NOP/READ/WRITE) into a complete APB transfer: SETUP phase, then ACCESS phase with wait states, on the APB bus toward one slave. It sits between the local control logic and the APB slave port. It returns read data, a completion pulse and a timeout error to the local side. Only one transfer is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 32, width of paddr_o / addr_i
- DATA_W, 32, width of all data buses
- TIMEOUT, 16, maximum ACCESS cycles with pready_i low before abort (≥1)

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- preset_n  in  1  reset, asynchronous, active-low
- add_i  in  2  command: 2'b00 NOP, 2'b01 READ, 2'b11 WRITE, 2'b10 treated as NOP
- addr_i  in  ADDR_W  transfer address, sampled with command
- wdata_i  in  DATA_W  write data, sampled with command
- busy_o  out  1  high in SETUP and ACCESS
- done_o  out  1  one-cycle completion pulse (success or timeout)
- err_o  out  1  valid with done_o: 1 = timeout abort
- rdata_o  out  DATA_W  last successful read data
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB direction, 1 = write
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- pready_i  in  1  APB slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - add_i = 01/11 at a rising edge loads paddr_o←addr_i and pwrite_o←add_i[1].
  - On WRITE, pwdata_o←wdata_i. On READ, pwdata_o is unchanged.
  - Next state is SETUP.
  - add_i = 00/10: stay in IDLE.
- SETUP: psel_o=1, penable_o=0. Unconditionally moves to ACCESS.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=1 at an edge completes the transfer:
    - READ: rdata_o←prdata_i.
    - done_o=1, err_o=0, next state IDLE.
  - pready_i=0: wait counter increments.
  - If the counter reaches TIMEOUT with pready_i still 0: done_o=1, err_o=1, rdata_o unchanged, next state IDLE.
- Wait counter: clog2(TIMEOUT+1) bits. Cleared on entry to SETUP. Never wraps.
- Commands are ignored while busy_o=1, including on the completion edge. The next command is accepted only from IDLE, so there is at least one idle cycle between transfers.
- paddr_o, pwrite_o and pwdata_o are held stable from SETUP through the end of ACCESS. They keep their last value in IDLE.
- err_o holds its value until the next done_o.
- Reset values: all outputs 0, FSM in IDLE.
  - Asserting reset mid-transfer drops psel_o/penable_o immediately (asynchronous).
  - No done_o is issued for the abandoned transfer.

## Timing
- Command sampled at edge T0. During T0→T1: SETUP, psel_o=1.
- At T1 → ACCESS: penable_o=1.
- Zero-wait slave (pready_i high at T2): done_o high during T2→T3, psel_o/penable_o low from T2. Latency command→done is 2 edges.
- Each wait state adds 1 cycle.
- Timeout with N = TIMEOUT: err_o/done_o assert after edge T1+N.
- rdata_o is updated on the same edge that raises done_o.
- busy_o = psel_o.

## Test plan
- Zero-wait READ, addr_i=0x10, prdata_i=0xDEADBEEF, pready_i high in ACCESS:
  - psel_o high for 2 cycles, penable_o for 1 cycle.
  - done_o one pulse, err_o=0, rdata_o=0xDEADBEEF, paddr_o=0x10, pwrite_o=0.
- WRITE, addr_i=0x24, wdata_i=0xA5A5_0001, slave holds pready_i low for 2 ACCESS cycles:
  - penable_o high 3 cycles.
  - pwdata_o/paddr_o stable throughout, pwrite_o=1.
  - done_o after 4 edges, rdata_o unchanged.
- NOP and 2'b10 commands for 5 cycles: psel_o, done_o and busy_o stay 0.
- READ issued while busy_o=1 during a write transfer: ignored, only one done_o.
- pready_i tied low with TIMEOUT=4:
  - ACCESS lasts 4 cycles, then done_o=1 with err_o=1.
  - Return to IDLE, rdata_o unchanged.
  - A following zero-wait read succeeds with err_o=0.
- preset_n asserted during ACCESS: psel_o/penable_o/busy_o go 0 immediately, no done_o, next READ after release behaves normally.
